block_ram_arbiter: RTL and testbench
====================================

BLOCK_RAM_ARBITER -- requirements
Module: block_ram_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin arbitration; 1 = port 0 always wins conflicts.
REQ-002 clock  input  1  single global clock; all state updates on posedge clock.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 p0_req  input  1  port 0 (instruction fetch) access request.
REQ-005 p0_addr  input  12  port 0 byte address; bits [11:2] select the word, bits [1:0] give the byte lane offset.
REQ-006 p0_wdata  input  32  port 0 write data, unshifted.
REQ-007 p0_wmask  input  4  port 0 byte-lane write mask.
REQ-008 p0_wren  input  1  port 0 access type: 1 = write, 0 = read.
REQ-009 p0_gnt  output  1  port 0 request accepted this cycle.
REQ-010 p0_rvalid  output  1  port 0 read data valid.
REQ-011 p0_rdata  output  32  port 0 read data.
REQ-012 p1_req, p1_addr, p1_wdata, p1_wmask, p1_wren, p1_gnt, p1_rvalid, p1_rdata: port 1 (data bus) signals; directions, widths and meanings identical to the port 0 signals in REQ-004 to REQ-011.
REQ-013 conflict_count  output  16  saturating count of cycles with both requests asserted.

Function
REQ-014 pX_gnt SHALL be combinational in the request cycle: gnt = req AND port selected AND NOT reset.
REQ-015 An access is accepted in a cycle where pX_req and pX_gnt are both 1; at most one port is granted per cycle.
REQ-016 Single requester: that port is granted unconditionally, with no idle cycle.
REQ-017 Both requesting, FIXED_PRIO=0: the port not granted most recently wins. The last_grant register SHALL update on every accepted access.
REQ-018 Both requesting, FIXED_PRIO=1: port 0 wins; last_grant still updates.
REQ-019 The granted port's addr/wdata/wmask/wren SHALL drive the RAM combinationally in the accept cycle.
REQ-020 No grant: RAM wren=0 and addr=0 (harmless read).
REQ-021 Accepted read: pX_rvalid=1 exactly one cycle later, with pX_rdata = the addressed word. This is fixed 1-cycle latency with no backpressure; a requester must take the data.
REQ-022 Accepted write: RAM performs the byte-lane shift and merge. Write data is shifted left 8 bits if addr[0] is set and 16 bits if addr[1] is set; unmasked lanes keep their old value.
REQ-023 Accepted write: no rvalid is generated for either port.
REQ-024 pX_rdata SHALL be 0 whenever pX_rvalid=0.
REQ-025 Back-to-back accepted reads on the same port SHALL give rvalid on consecutive cycles (full throughput).
REQ-026 Read to a word written in the previous cycle SHALL return the newly written data.
REQ-027 Same-cycle read and write from different ports is impossible, because one grant is issued per cycle. The loser's req stays asserted and its fields stay stable until gnt.
REQ-028 conflict_count increments when p0_req and p1_req are both 1, and holds at 16'hFFFF.

Reset
REQ-029 While reset=1: p0_gnt=p1_gnt=0, RAM wren forced to 0, and requests are ignored.
REQ-030 After reset: p0_rvalid=p1_rvalid=0, both rdata outputs=0, last_grant=port 1 (so port 0 wins the first conflict), conflict_count=0.
REQ-031 Reset asserted the cycle after an accepted read SHALL suppress that read's rvalid.
REQ-032 RAM contents are not reset.

Structure
REQ-033 Shared package pinwheel_mem_pkg holds: RAM_ADDR_W=12, RAM_DATA_W=32, RAM_MASK_W=4, and the port-id enum (PORT_CODE=0, PORT_DATA=1).
REQ-034 The block SHALL instantiate exactly one block_ram sub-module; the arbiter owns its tock inputs and consumes its rdata.
REQ-035 Sequential state: last_grant (1 bit), rsp_valid (1 bit), rsp_port (1 bit), conflict_count (16 bits).

Verification
REQ-036 Port 1 writes 0xDEADBEEF to addr 0x010 with mask 0xF; port 0 reads 0x010 next cycle -> p0_rvalid one cycle later, p0_rdata=0xDEADBEEF.
REQ-037 Word 0x020 preset to 0x11223344; port 1 writes 0x000000AB to addr 0x021 with mask 0x2 -> a subsequent read returns 0x1122AB44.
REQ-038 Both ports hold req for 4 cycles after reset (FIXED_PRIO=0) -> grants go p0, p1, p0, p1; conflict_count=4; each read's rvalid arrives on its own port only.
REQ-039 Same as REQ-038 with FIXED_PRIO=1 -> p0 is granted all 4 cycles, p1 is never granted.
REQ-040 Port 0 reads in cycle N and reset is asserted in cycle N+1 -> p0_rvalid=0 in cycle N+1 and p0_rdata=0; after reset, port 0 wins the first conflict.
REQ-041 Force conflict_count to 0xFFFE, then apply 3 conflict cycles -> the count reads 0xFFFF and stays there.

Source files
------------

// File: rtl/pinwheel_mem_pkg.sv
// Shared memory-subsystem definitions: RAM geometry and the port identifiers
// used by the block RAM arbiter.
package pinwheel_mem_pkg;

   localparam int RAM_ADDR_W = 12;
   localparam int RAM_DATA_W = 32;
   localparam int RAM_MASK_W = 4;
   localparam int RAM_LANE_W = RAM_DATA_W / RAM_MASK_W;
   localparam int RAM_WORD_W = RAM_ADDR_W - 2;
   localparam int RAM_WORDS  = 1 << RAM_WORD_W;

   typedef enum logic {
      PORT_CODE = 1'b0,
      PORT_DATA = 1'b1
   } port_id_e;

endpackage

// File: rtl/block_ram.sv
// Single-port word RAM with byte-lane write enables and a registered read.
// Write data arrives unshifted and is aligned here to the byte offset of the address.
module block_ram
   import pinwheel_mem_pkg::*;
(
   input  logic                  clock,
   input  logic                  wren,
   input  logic [RAM_ADDR_W-1:0] addr,
   input  logic [RAM_DATA_W-1:0] wdata,
   input  logic [RAM_MASK_W-1:0] wmask,
   output logic [RAM_DATA_W-1:0] rdata
);

   logic [RAM_DATA_W-1:0] mem [RAM_WORDS];
   logic [RAM_WORD_W-1:0] word;
   logic [RAM_DATA_W-1:0] shifted;

   assign word = addr[RAM_ADDR_W-1:2];

   // A byte offset of 1/2/3 moves the data up 8/16/24 bits; the mask then
   // selects lanes in their final position.
   always_comb begin
      shifted = wdata << {addr[1:0], 3'b000};
   end

   // Contents are deliberately left unreset.
   always_ff @(posedge clock) begin
      for (int i = 0; i < RAM_MASK_W; i++) begin
         if (wren && wmask[i]) begin
            mem[word][RAM_LANE_W*i +: RAM_LANE_W] <= shifted[RAM_LANE_W*i +: RAM_LANE_W];
         end
      end
      rdata <= mem[word];
   end

endmodule

// File: rtl/block_ram_arbiter.sv
// Two-port arbiter sharing one block RAM between instruction fetch (port 0)
// and the data bus (port 1), with round-robin or fixed-priority conflict resolution.
module block_ram_arbiter
   import pinwheel_mem_pkg::*;
#(
   parameter int FIXED_PRIO = 0
)
(
   input  logic                  clock,
   input  logic                  reset,

   input  logic                  p0_req,
   input  logic [RAM_ADDR_W-1:0] p0_addr,
   input  logic [RAM_DATA_W-1:0] p0_wdata,
   input  logic [RAM_MASK_W-1:0] p0_wmask,
   input  logic                  p0_wren,
   output logic                  p0_gnt,
   output logic                  p0_rvalid,
   output logic [RAM_DATA_W-1:0] p0_rdata,

   input  logic                  p1_req,
   input  logic [RAM_ADDR_W-1:0] p1_addr,
   input  logic [RAM_DATA_W-1:0] p1_wdata,
   input  logic [RAM_MASK_W-1:0] p1_wmask,
   input  logic                  p1_wren,
   output logic                  p1_gnt,
   output logic                  p1_rvalid,
   output logic [RAM_DATA_W-1:0] p1_rdata,

   output logic [15:0]           conflict_count
);

   port_id_e              last_grant;
   logic                  rsp_valid;
   port_id_e              rsp_port;

   logic                  ram_wren;
   logic [RAM_ADDR_W-1:0] ram_addr;
   logic [RAM_DATA_W-1:0] ram_wdata;
   logic [RAM_MASK_W-1:0] ram_wmask;
   logic [RAM_DATA_W-1:0] ram_rdata;

   logic                  conflict;

   assign conflict = p0_req && p1_req;

   // On a conflict the port that did not win last time goes next, unless
   // fixed priority is selected, in which case instruction fetch always wins.
   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (!reset) begin
         if (conflict) begin
            if (FIXED_PRIO != 0 || last_grant == PORT_DATA) begin
               p0_gnt = 1'b1;
            end else begin
               p1_gnt = 1'b1;
            end
         end else if (p0_req) begin
            p0_gnt = 1'b1;
         end else if (p1_req) begin
            p1_gnt = 1'b1;
         end
      end
   end

   // Idle cycles present a harmless read of word 0 to the RAM.
   always_comb begin
      ram_wren  = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_wmask = '0;
      if (p0_gnt) begin
         ram_wren  = p0_wren;
         ram_addr  = p0_addr;
         ram_wdata = p0_wdata;
         ram_wmask = p0_wmask;
      end else if (p1_gnt) begin
         ram_wren  = p1_wren;
         ram_addr  = p1_addr;
         ram_wdata = p1_wdata;
         ram_wmask = p1_wmask;
      end
   end

   block_ram u_ram (
      .clock (clock),
      .wren  (ram_wren),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .wmask (ram_wmask),
      .rdata (ram_rdata)
   );

   // Remember which port owns the read returning next cycle; writes return nothing.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant     <= PORT_DATA;
         rsp_valid      <= 1'b0;
         rsp_port       <= PORT_CODE;
         conflict_count <= '0;
      end else begin
         if (p0_gnt || p1_gnt) begin
            last_grant <= p1_gnt ? PORT_DATA : PORT_CODE;
         end
         rsp_valid <= (p0_gnt && !p0_wren) || (p1_gnt && !p1_wren);
         rsp_port  <= p1_gnt ? PORT_DATA : PORT_CODE;
         if (conflict && conflict_count != 16'hFFFF) begin
            conflict_count <= conflict_count + 16'd1;
         end
      end
   end

   // Reset in the response cycle kills the pending read.
   assign p0_rvalid = rsp_valid && rsp_port == PORT_CODE && !reset;
   assign p1_rvalid = rsp_valid && rsp_port == PORT_DATA && !reset;
   assign p0_rdata  = p0_rvalid ? ram_rdata : '0;
   assign p1_rdata  = p1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Directed bench for block_ram_arbiter: one round-robin and one fixed-priority
// instance share the request inputs.
module tb_block_ram_arbiter;

   logic        clock;
   logic        reset;
   logic        p0_req, p1_req, p0_wren, p1_wren;
   logic [11:0] p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata;
   logic [3:0]  p0_wmask, p1_wmask;

   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [31:0] p0_rdata, p1_rdata;
   logic [15:0] conflict_count;

   logic        fp_p0_gnt, fp_p1_gnt, fp_p0_rvalid, fp_p1_rvalid;
   logic [31:0] fp_p0_rdata, fp_p1_rdata;
   logic [15:0] fp_conflict_count;

   int errors = 0;
   int checks = 0;

   block_ram_arbiter #(.FIXED_PRIO(0)) dut (
      .clock(clock), .reset(reset),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
      .p0_wren(p0_wren), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
      .p1_wren(p1_wren), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .conflict_count(conflict_count)
   );

   block_ram_arbiter #(.FIXED_PRIO(1)) dut_fp (
      .clock(clock), .reset(reset),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
      .p0_wren(p0_wren), .p0_gnt(fp_p0_gnt), .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
      .p1_wren(p1_wren), .p1_gnt(fp_p1_gnt), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata),
      .conflict_count(fp_conflict_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      p0_req = 1'b0; p1_req = 1'b0; p0_wren = 1'b0; p1_wren = 1'b0;
      p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
      p0_wmask = '0; p1_wmask = '0;
   endtask

   task automatic drive_p0(input logic wren, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask);
      p0_req = 1'b1; p0_wren = wren; p0_addr = addr; p0_wdata = wdata; p0_wmask = wmask;
   endtask

   task automatic drive_p1(input logic wren, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask);
      p1_req = 1'b1; p1_wren = wren; p1_addr = addr; p1_wdata = wdata; p1_wmask = wmask;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_p0(1'b0, 12'h000, 32'h0, 4'h0);
      drive_p1(1'b0, 12'h000, 32'h0, 4'h0);
      #1;
      checks++;
      if ({p0_gnt, p1_gnt} !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_gnt: got %b expected 00", {p0_gnt, p1_gnt});
      end
      tick();
      idle();
      reset = 1'b0;
      #1;
      checks++;
      if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_rvalid: got %b expected 00", {p0_rvalid, p1_rvalid});
      end
      checks++;
      if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", p0_rdata, p1_rdata);
      end
      checks++;
      if (conflict_count !== 16'h0) begin
         errors++; $display("[TB] FAIL reset_count: got %h expected 0000", conflict_count);
      end
   endtask

   task automatic test_write_read();
      drive_p1(1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
      #1;
      checks++;
      if ({p0_gnt, p1_gnt} !== 2'b01) begin
         errors++; $display("[TB] FAIL wr_gnt: got %b expected 01", {p0_gnt, p1_gnt});
      end
      tick();
      idle();
      drive_p0(1'b0, 12'h010, 32'h0, 4'h0);
      #1;
      checks++;
      if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
         errors++; $display("[TB] FAIL wr_no_rvalid: got %b expected 00", {p0_rvalid, p1_rvalid});
      end
      checks++;
      if ({p0_gnt, p1_gnt} !== 2'b10) begin
         errors++; $display("[TB] FAIL rd_gnt: got %b expected 10", {p0_gnt, p1_gnt});
      end
      tick();
      idle();
      checks++;
      if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p1_rvalid !== 1'b0) begin
         errors++; $display("[TB] FAIL rd_data: got v=%b d=%h p1v=%b expected v=1 d=deadbeef p1v=0",
                            p0_rvalid, p0_rdata, p1_rvalid);
      end
      tick();
      checks++;
      if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin
         errors++; $display("[TB] FAIL rd_idle: got v=%b d=%h expected v=0 d=0", p0_rvalid, p0_rdata);
      end
   endtask

   task automatic test_byte_merge();
      drive_p1(1'b1, 12'h020, 32'h11223344, 4'hF);
      tick();
      drive_p1(1'b1, 12'h021, 32'h000000AB, 4'h2);
      tick();
      drive_p1(1'b0, 12'h020, 32'h0, 4'h0);
      tick();
      drive_p1(1'b1, 12'h023, 32'h00000055, 4'h8);
      checks++;
      if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h1122AB44) begin
         errors++; $display("[TB] FAIL merge_lane1: got v=%b d=%h expected v=1 d=1122ab44", p1_rvalid, p1_rdata);
      end
      tick();
      drive_p1(1'b1, 12'h022, 32'h00000066, 4'h4);
      tick();
      drive_p1(1'b0, 12'h020, 32'h0, 4'h0);
      tick();
      idle();
      checks++;
      if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h5566AB44) begin
         errors++; $display("[TB] FAIL merge_lane23: got v=%b d=%h expected v=1 d=5566ab44", p1_rvalid, p1_rdata);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [11:0] addrs [3];
      logic [31:0] datas [3];
      addrs[0] = 12'h030; addrs[1] = 12'h034; addrs[2] = 12'h030;
      datas[0] = 32'hA0A0A0A0; datas[1] = 32'h0B0B0B0B; datas[2] = 32'hA0A0A0A0;
      drive_p0(1'b1, 12'h030, 32'hA0A0A0A0, 4'hF);
      tick();
      drive_p0(1'b1, 12'h034, 32'h0B0B0B0B, 4'hF);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive_p0(1'b0, addrs[i], 32'h0, 4'h0);
         tick();
         checks++;
         if (p0_rvalid !== 1'b1 || p0_rdata !== datas[i]) begin
            errors++; $display("[TB] FAIL b2b_%0d: got v=%b d=%h expected v=1 d=%h", i, p0_rvalid, p0_rdata, datas[i]);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_conflict_arbitration();
      logic exp_p0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive_p0(1'b0, 12'h010, 32'h0, 4'h0);
      drive_p1(1'b0, 12'h020, 32'h0, 4'h0);
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_p0 = (k % 2 == 0);
         checks++;
         if (p0_gnt !== exp_p0 || p1_gnt !== !exp_p0) begin
            errors++; $display("[TB] FAIL rr_gnt_%0d: got %b%b expected %b%b", k, p0_gnt, p1_gnt, exp_p0, !exp_p0);
         end
         checks++;
         if ({fp_p0_gnt, fp_p1_gnt} !== 2'b10) begin
            errors++; $display("[TB] FAIL fp_gnt_%0d: got %b%b expected 10", k, fp_p0_gnt, fp_p1_gnt);
         end
         if (k > 0) begin
            checks++;
            if (p0_rvalid !== !exp_p0 || p1_rvalid !== exp_p0 ||
                p0_rdata !== (exp_p0 ? 32'h0 : 32'hDEADBEEF) ||
                p1_rdata !== (exp_p0 ? 32'h5566AB44 : 32'h0)) begin
               errors++; $display("[TB] FAIL rr_rsp_%0d: got v=%b%b d=%h/%h", k, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata);
            end
         end
         tick();
      end
      idle();
      #1;
      checks++;
      if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b1 || p1_rdata !== 32'h5566AB44) begin
         errors++; $display("[TB] FAIL rr_last_rsp: got v=%b%b d=%h expected v=01 d=5566ab44", p0_rvalid, p1_rvalid, p1_rdata);
      end
      checks++;
      if (fp_p0_rvalid !== 1'b1 || fp_p1_rvalid !== 1'b0 || fp_p0_rdata !== 32'hDEADBEEF) begin
         errors++; $display("[TB] FAIL fp_last_rsp: got v=%b%b d=%h expected v=10 d=deadbeef", fp_p0_rvalid, fp_p1_rvalid, fp_p0_rdata);
      end
      checks++;
      if (conflict_count !== 16'd4 || fp_conflict_count !== 16'd4) begin
         errors++; $display("[TB] FAIL conflict_4: got %0d/%0d expected 4/4", conflict_count, fp_conflict_count);
      end
      tick();
   endtask

   task automatic test_reset_after_read();
      drive_p0(1'b0, 12'h010, 32'h0, 4'h0);
      #1;
      checks++;
      if (p0_gnt !== 1'b1) begin
         errors++; $display("[TB] FAIL rar_gnt: got %b expected 1", p0_gnt);
      end
      tick();
      idle();
      reset = 1'b1;
      #1;
      checks++;
      if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin
         errors++; $display("[TB] FAIL rar_suppress: got v=%b d=%h expected v=0 d=0", p0_rvalid, p0_rdata);
      end
      tick();
      reset = 1'b0;
      drive_p0(1'b0, 12'h010, 32'h0, 4'h0);
      drive_p1(1'b0, 12'h020, 32'h0, 4'h0);
      #1;
      checks++;
      if ({p0_gnt, p1_gnt} !== 2'b10) begin
         errors++; $display("[TB] FAIL rar_first_conflict: got %b expected 10", {p0_gnt, p1_gnt});
      end
      tick();
      idle();
      tick();
   endtask

   task automatic test_saturation();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive_p0(1'b0, 12'h000, 32'h0, 4'h0);
      drive_p1(1'b0, 12'h000, 32'h0, 4'h0);
      repeat (65534) tick();
      checks++;
      if (conflict_count !== 16'hFFFE) begin
         errors++; $display("[TB] FAIL sat_fffe: got %h expected fffe", conflict_count);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (conflict_count !== 16'hFFFF) begin
            errors++; $display("[TB] FAIL sat_hold_%0d: got %h expected ffff", i, conflict_count);
         end
      end
      idle();
      tick();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      repeat (3) tick();
      test_reset();
      test_write_read();
      test_byte_merge();
      test_back_to_back();
      test_conflict_arbitration();
      test_reset_after_read();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
